// File: rtl/ep_bins_if.sv
// ep_bins_if: request/bitstream bundle between the context FSM, bit feeder and the EP bypass sequencer.
// The abort signal exists only when EP_ABORT_EN is defined.
interface ep_bins_if #(parameter int MAX_BINS = 32);
    logic                start;
    logic [5:0]          num_bins;
    logic [8:0]          range_in;
    logic [15:0]         value_in;
    logic                bit_valid;
    logic                bit_in;
    logic                bit_ready;
    logic                busy;
    logic                done;
    logic [MAX_BINS-1:0] bins_out;
    logic [15:0]         value_out;
`ifdef EP_ABORT_EN
    logic                abort;
    modport master (output start, num_bins, range_in, value_in, bit_valid, bit_in, abort,
                    input  bit_ready, busy, done, bins_out, value_out);
    modport slave  (input  start, num_bins, range_in, value_in, bit_valid, bit_in, abort,
                    output bit_ready, busy, done, bins_out, value_out);
`else
    modport master (output start, num_bins, range_in, value_in, bit_valid, bit_in,
                    input  bit_ready, busy, done, bins_out, value_out);
    modport slave  (input  start, num_bins, range_in, value_in, bit_valid, bit_in,
                    output bit_ready, busy, done, bins_out, value_out);
`endif
endinterface

// File: rtl/ep_bins_sequencer.sv
// ep_bins_sequencer: decodes up to MAX_BINS bypass bins, one bitstream bit per step, MSB-first.
// Optional abort input enabled by defining EP_ABORT_EN.
module ep_bins_sequencer #(
    parameter int MAX_BINS = 32
) (
    input logic       clk,
    input logic       rst_n,
    ep_bins_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [15:0]         scaled_q, scaled_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [MAX_BINS-1:0] acc_q, acc_d;
    logic [15:0]         val_q, val_d;
    logic [MAX_BINS-1:0] bins_out_q, bins_out_d;
    logic [15:0]         value_out_q, value_out_d;
    logic [16:0]         t;
    logic [15:0]         diff;
    logic                bin;
    logic [5:0]          sat;

    always_comb begin
        state_d     = state_q;
        scaled_d    = scaled_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        val_d       = val_q;
        bins_out_d  = bins_out_q;
        value_out_d = value_out_q;
        t    = {val_q, bus.bit_in};
        bin  = t >= {1'b0, scaled_q};
        diff = t[15:0] - scaled_q;
        sat  = (int'(bus.num_bins) > MAX_BINS) ? 6'(MAX_BINS) : bus.num_bins;
        case (state_q)
            IDLE: if (bus.start) begin
                scaled_d = {bus.range_in, 7'b0};
                cnt_d    = sat;
                acc_d    = '0;
                val_d    = bus.value_in;
                state_d  = (sat != 6'd0) ? RUN : DONE;
            end
            RUN: if (bus.bit_valid) begin
                val_d   = bin ? diff : t[15:0];
                acc_d   = {acc_q[MAX_BINS-2:0], bin};
                cnt_d   = cnt_q - 6'd1;
                state_d = (cnt_q == 6'd1) ? DONE : RUN;
            end
            default: state_d = IDLE;
        endcase
`ifdef EP_ABORT_EN
        if (bus.abort && state_q != IDLE) state_d = IDLE;
`endif
        // Results are published on entry to DONE so they are visible alongside the done pulse.
        if (state_d == DONE) begin
            bins_out_d  = acc_d;
            value_out_d = val_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            scaled_q    <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            val_q       <= '0;
            bins_out_q  <= '0;
            value_out_q <= '0;
        end else begin
            state_q     <= state_d;
            scaled_q    <= scaled_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            val_q       <= val_d;
            bins_out_q  <= bins_out_d;
            value_out_q <= value_out_d;
        end
    end

    assign bus.bit_ready = state_q == RUN;
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == DONE;
    assign bus.bins_out  = bins_out_q;
    assign bus.value_out = value_out_q;
endmodule

// File: tb/tb_ep_bins_sequencer.sv
// tb_ep_bins_sequencer: directed-vector bench for ep_bins_sequencer (abort scenario under EP_ABORT_EN).
module tb_ep_bins_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ep_bins_if #(.MAX_BINS(32)) bus ();
    ep_bins_sequencer #(.MAX_BINS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    // Cycle 0 is the cycle start is driven; bit i of bits is the i-th bit fed.
    task automatic run_req(input logic [8:0] r, input logic [15:0] v, input logic [5:0] n,
                           input logic [31:0] bits, input int gap, input bit poke,
                           output int dcyc, output int rdy);
        int cyc, idx, g;
        dcyc = -1; rdy = 0; idx = 0; g = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.range_in = r; bus.value_in = v; bus.num_bins = n;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (cyc = 1; cyc < 200; cyc++) begin
            if (bus.done) begin
                dcyc = cyc;
                break;
            end
            if (bus.bit_ready) rdy++;
            bus.bit_valid = 1'b0;
            if (bus.bit_ready) begin
                if (g < gap) g++;
                else begin
                    bus.bit_valid = 1'b1;
                    bus.bit_in = (idx < 32) ? bits[idx] : 1'b0;
                    idx++;
                    g = 0;
                end
            end
            if (poke) begin
                bus.start = 1'b1; bus.num_bins = 6'd1; bus.value_in = 16'd0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.start = 1'b0; bus.bit_valid = 1'b0;
        if (dcyc < 0) begin
            errors++;
            $display("FAIL run_req timeout: no done within 200 cycles");
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if ({bus.busy, bus.done, bus.bit_ready} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {bus.busy, bus.done, bus.bit_ready}); end
        checks++; if (bus.bins_out !== 32'd0) begin errors++; $display("FAIL reset_bins got %h want 0", bus.bins_out); end
        checks++; if (bus.value_out !== 16'd0) begin errors++; $display("FAIL reset_value got %0d want 0", bus.value_out); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int d, r;
        run_req(9'd256, 16'd20000, 6'd3, 32'h2, 0, 1'b0, d, r);
        checks++; if (d !== 4) begin errors++; $display("FAIL basic_done_cycle got %0d want 4", d); end
        checks++; if (r !== 3) begin errors++; $display("FAIL basic_ready_cycles got %0d want 3", r); end
        checks++; if (bus.bins_out !== 32'h4) begin errors++; $display("FAIL basic_bins got %h want 4", bus.bins_out); end
        checks++; if (bus.value_out !== 16'd28930) begin errors++; $display("FAIL basic_value got %0d want 28930", bus.value_out); end
    endtask

    task automatic test_full(input logic [5:0] n, input string nm);
        int d, r;
        run_req(9'd510, 16'd65279, n, 32'hFFFFFFFF, 0, 1'b0, d, r);
        checks++; if (d !== 33) begin errors++; $display("FAIL %s_done_cycle got %0d want 33", nm, d); end
        checks++; if (r !== 32) begin errors++; $display("FAIL %s_ready_cycles got %0d want 32", nm, r); end
        checks++; if (bus.bins_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL %s_bins got %h want ffffffff", nm, bus.bins_out); end
        checks++; if (bus.value_out !== 16'd65279) begin errors++; $display("FAIL %s_value got %0d want 65279", nm, bus.value_out); end
    endtask

    task automatic test_zero();
        int d, r;
        run_req(9'd256, 16'd1234, 6'd0, 32'h0, 0, 1'b0, d, r);
        checks++; if (d !== 1) begin errors++; $display("FAIL zero_done_cycle got %0d want 1", d); end
        checks++; if (r !== 0) begin errors++; $display("FAIL zero_ready_cycles got %0d want 0", r); end
        checks++; if (bus.bins_out !== 32'd0) begin errors++; $display("FAIL zero_bins got %h want 0", bus.bins_out); end
        checks++; if (bus.value_out !== 16'd1234) begin errors++; $display("FAIL zero_value got %0d want 1234", bus.value_out); end
    endtask

    task automatic test_stall();
        int d, r;
        run_req(9'd256, 16'd20000, 6'd3, 32'h2, 2, 1'b1, d, r);
        checks++; if (d !== 10) begin errors++; $display("FAIL stall_done_cycle got %0d want 10", d); end
        checks++; if (r !== 9) begin errors++; $display("FAIL stall_ready_cycles got %0d want 9", r); end
        checks++; if (bus.bins_out !== 32'h4) begin errors++; $display("FAIL stall_bins got %h want 4", bus.bins_out); end
        checks++; if (bus.value_out !== 16'd28930) begin errors++; $display("FAIL stall_value got %0d want 28930", bus.value_out); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.start = 1'b1; bus.range_in = 9'd256; bus.value_in = 16'd20000; bus.num_bins = 6'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.bit_valid = 1'b1; bus.bit_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.done, bus.bit_ready} !== 3'b000) begin errors++; $display("FAIL areset_flags got %b want 000", {bus.busy, bus.done, bus.bit_ready}); end
        checks++; if (bus.bins_out !== 32'd0) begin errors++; $display("FAIL areset_bins got %h want 0", bus.bins_out); end
        checks++; if (bus.value_out !== 16'd0) begin errors++; $display("FAIL areset_value got %0d want 0", bus.value_out); end
        bus.bit_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.start = 1'b1; bus.range_in = 9'd256; bus.value_in = 16'd16384; bus.num_bins = 6'd1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.bit_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", bus.bit_ready); end
        bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b want 1", bus.done); end
        checks++; if ({bus.bins_out, bus.value_out} !== {32'd1, 16'd1}) begin errors++; $display("FAIL b2b_result1 got %h/%0d want 1/1", bus.bins_out, bus.value_out); end
        bus.bit_valid = 1'b0;
        bus.start = 1'b1; bus.num_bins = 6'd0; bus.value_in = 16'd777;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL b2b_gap got %b want 00", {bus.busy, bus.done}); end
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b want 1", bus.done); end
        checks++; if ({bus.bins_out, bus.value_out} !== {32'd0, 16'd777}) begin errors++; $display("FAIL b2b_result2 got %h/%0d want 0/777", bus.bins_out, bus.value_out); end
        @(negedge clk);
    endtask

`ifdef EP_ABORT_EN
    task automatic test_abort();
        test_basic();
        @(negedge clk);
        bus.start = 1'b1; bus.range_in = 9'd510; bus.value_in = 16'd65279; bus.num_bins = 6'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b0; bus.bit_valid = 1'b0;
        checks++; if ({bus.busy, bus.bit_ready, bus.done} !== 3'b000) begin errors++; $display("FAIL abort_flags got %b want 000", {bus.busy, bus.bit_ready, bus.done}); end
        checks++; if (bus.bins_out !== 32'h4) begin errors++; $display("FAIL abort_bins got %h want 4", bus.bins_out); end
        checks++; if (bus.value_out !== 16'd28930) begin errors++; $display("FAIL abort_value got %0d want 28930", bus.value_out); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b want 0", bus.done); end
        end
    endtask
`endif

    initial begin
        bus.start = 1'b0; bus.num_bins = '0; bus.range_in = 9'd256; bus.value_in = '0;
        bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
`ifdef EP_ABORT_EN
        bus.abort = 1'b0;
`endif
        test_reset();
        test_basic();
        test_full(6'd32, "full");
        test_full(6'd63, "saturate");
        test_zero();
        test_stall();
        test_async_reset();
        test_back_to_back();
`ifdef EP_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ep_bins_sequencer.md
# ep_bins_sequencer

Multi-bin bypass (equiprobable) decoding controller for the VVC arithmetic decoder. It sequences one single-step EP operation per accepted bitstream bit (value shift-in, compare against scaled range, conditional subtract) for up to 32 consecutive bypass bins. It accumulates the decoded bins MSB-first and returns the updated arithmetic-decoder value. It sits between the context-decoding control FSM, which issues bypass runs, and the bit-serial bitstream feeder.

## Interface
Parameters:
- MAX_BINS, 32, maximum bins per request; bins_out width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; sampled only in IDLE.
- num_bins  in  6  number of bins to decode, 0..32; values above 32 are treated as 32.
- range_in  in  9  current arithmetic range, 256..510; latched at start.
- value_in  in  16  current decoder value; latched at start. Contract: value_in < range_in<<7.
- bit_valid  in  1  bitstream bit available.
- bit_in  in  1  next bitstream bit.
- bit_ready  out  1  sequencer consumes bit_in this cycle when bit_valid is also high.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- bins_out  out  MAX_BINS  decoded bins, right-aligned, first decoded bin most significant.
- value_out  out  16  updated decoder value.
- abort  in  1  present only with EP_ABORT_EN.

## Operation
- Reset values: state=IDLE, bit_ready=0, busy=0, done=0, bins_out=0, value_out=0, all internal registers 0.
- Latched at start: scaled = range_in<<7 (16 bits), cnt = num_bins (saturated to 32), acc = 0, val = value_in.
- FSM states:
  - IDLE: when start=1, latch the inputs above. Go to RUN if cnt≠0, else go to DONE.
  - RUN: bit_ready=1. On each cycle with bit_valid=1, perform one step:
    - t = {val,1'b0} | bit_in (17 bits)
    - bin = (t >= scaled)
    - val = bin ? t−scaled : t[15:0]
    - acc = {acc[30:0], bin}
    - cnt = cnt−1
    - On the step where cnt goes 1→0, go to DONE.
    - bit_valid=0: hold all state, no step taken.
  - DONE: done=1; bins_out=acc; value_out=val. Return to IDLE.
- Arithmetic: the comparison uses the full 17-bit t. The subtraction result always fits in 16 bits when the input contract holds. If the contract is violated, the FSM still completes in exactly cnt steps; the numeric results are unspecified.
- bins_out and value_out hold their values from DONE until the next DONE.
- A start that arrives while busy is ignored; it is neither queued nor flagged.
- num_bins=0: no bits are consumed, done pulses, bins_out=0, value_out=value_in.

## Timing
- Accepting start: IDLE→RUN on the clock edge where start=1.
- With bit_valid held high: start in cycle 0, bit consumption in cycles 1..N, done in cycle N+1. Minimum request-to-done latency is N+1 cycles.
- Each cycle with bit_valid=0 in RUN adds one cycle of latency.
- Throughput: one bin per cycle; back-to-back requests have a 1-cycle IDLE gap, so a new start is accepted at the earliest in the cycle after done.
- bit_ready is a registered state decode and does not depend combinationally on bit_valid.
- rst_n assertion mid-run forces all outputs to their reset values immediately; any consumed bits are lost.

## Configuration
- EP_ABORT_EN defined:
  - Adds the abort input.
  - abort=1 in RUN or DONE forces IDLE on the next edge. done is not pulsed, bins_out and value_out are left unchanged, and bit_ready drops in the next cycle.
  - abort has priority over a step occurring in the same cycle; that bit is still counted as consumed by the feeder.
  - abort in IDLE has no effect.
- EP_ABORT_EN undefined: no abort port; every accepted request runs to completion.

## Test plan
- range_in=256, value_in=20000, num_bins=3, bits 0,1,0 with bit_valid held high:
  - done in cycle 4
  - bins_out=0x4
  - value_out=28930
- range_in=510, value_in=65279, num_bins=32, all bits 1:
  - done in cycle 33
  - bins_out=0xFFFFFFFF
  - value_out=65279
- num_bins=0, value_in=1234: done in cycle 1, no bit_ready cycles, bins_out=0, value_out=1234.
- First case with bit_valid low for 2 cycles before each bit: done in cycle 10, same results; start pulses during busy are ignored.
- rst_n low in cycle 2 of a 3-bin run: busy, done and bit_ready drop to 0 immediately, and outputs are 0. A fresh start after release completes correctly.
- EP_ABORT_EN: abort in cycle 2 of the first case gives no done pulse, prior bins_out/value_out retained, and busy=0 from cycle 3.
